// File: rtl/ras_ptr_ctrl_pkg.sv
// ras_ptr_ctrl_pkg: shared types for the return-address-stack pointer controller.
package ras_ptr_ctrl_pkg;

    typedef struct packed {
        logic [31:0] XLEN;
    } cvw_t;

    localparam cvw_t RAS_DEFAULT_CFG = '{XLEN: 32'd64};

    typedef enum logic {
        RAS_CLEAR,
        RAS_RUN
    } ras_state_t;

endpackage

// File: rtl/ras_ptr_ctrl.sv
// ras_ptr_ctrl: RAS pointer/occupancy controller; clears the array after reset, then
// folds pop/push/repair events into one net pointer update per cycle.
module ras_ptr_ctrl
    import ras_ptr_ctrl_pkg::*;
#(
    parameter cvw_t P         = RAS_DEFAULT_CFG,
    parameter int   StackSize = 16,
    localparam int  Depth     = $clog2(StackSize)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallD,
    input  logic              StallE,
    input  logic              StallM,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic              FlushM,
    input  logic              BPReturnF,
    input  logic              ReturnD,
    input  logic              BPReturnWrongD,
    input  logic              ReturnE,
    input  logic              CallE,
    input  logic [P.XLEN-1:0] PCLinkE,
    output logic [Depth-1:0]  RASPtr,
    output logic              RASWrEn,
    output logic [Depth-1:0]  RASWrAdr,
    output logic [P.XLEN-1:0] RASWrData,
    output logic              RASValidF,
    output logic              RASBusy
);

    ras_state_t              r_state, w_state_nxt;
    logic [Depth-1:0]        r_ptr, r_clr_cnt, w_ptr_nxt, w_wr_adr;
    logic [Depth:0]          r_count, w_count_nxt;
    logic                    w_run, w_pop_f, w_push_e, w_wrong_d, w_fl_ret, w_inc_rep, w_dec_rep;
    logic signed [2:0]       w_delta;
    logic signed [Depth+1:0] w_count_sum;

    assign w_run     = (r_state == RAS_RUN);
    assign w_pop_f   = BPReturnF & ~StallD & ~FlushD;
    assign w_push_e  = CallE & ~StallM & ~FlushM;
    assign w_wrong_d = BPReturnWrongD & ~StallE & ~FlushE;
    assign w_fl_ret  = (~StallE & FlushE & ReturnD) | (FlushM & ReturnE);
    assign w_inc_rep = w_fl_ret | (w_wrong_d & ~ReturnD);
    assign w_dec_rep = w_wrong_d & ReturnD;

    assign w_delta = $signed({2'b00, w_push_e}) + $signed({2'b00, w_inc_rep})
                   - $signed({2'b00, w_pop_f}) - $signed({2'b00, w_dec_rep});

    // Pointer wraps freely; occupancy saturates at both ends.
    assign w_ptr_nxt   = r_ptr + Depth'(w_delta);
    assign w_count_sum = $signed({1'b0, r_count}) + (Depth+2)'(w_delta);
    assign w_count_nxt = w_count_sum[Depth+1] ? '0 :
                         (w_count_sum[Depth:0] > (Depth+1)'(StackSize)) ? (Depth+1)'(StackSize) :
                         w_count_sum[Depth:0];

    // Repair precedes the push, so the push lands just above the repaired top.
    assign w_wr_adr = r_ptr + Depth'(w_inc_rep) - Depth'(w_dec_rep) + Depth'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RAS_CLEAR;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        RASWrEn     = 1'b0;
        RASWrAdr    = '0;
        RASWrData   = '0;
        RASBusy     = 1'b0;
        if (r_state == RAS_CLEAR) begin
            RASWrEn  = 1'b1;
            RASWrAdr = r_clr_cnt;
            RASBusy  = 1'b1;
            if (r_clr_cnt == Depth'(StackSize-1)) w_state_nxt = RAS_RUN;
        end else begin
            RASWrEn   = w_push_e;
            RASWrAdr  = w_wr_adr;
            RASWrData = PCLinkE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_clr_cnt <= '0;
        else if (!w_run) r_clr_cnt <= r_clr_cnt + Depth'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_run) begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign RASPtr    = r_ptr;
    assign RASValidF = w_run & (r_count != '0);

endmodule
